// File: rtl/regfile_op_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// regfile_op_sequencer_pkg
// Shared definitions for the register-file operation sequencer:
//   - op-code constants (OP_MOV, OP_ADD, OP_SUB, OP_LDI)
//   - FSM state encoding (IDLE, READ, EXEC, WRITE)
//   - default datapath width (matches the 2 x 8-bit register file)
// -----------------------------------------------------------------------------
package regfile_op_sequencer_pkg;

    localparam int DATA_W_DEF = 8;

    localparam logic [1:0] OP_MOV = 2'd0;
    localparam logic [1:0] OP_ADD = 2'd1;
    localparam logic [1:0] OP_SUB = 2'd2;
    localparam logic [1:0] OP_LDI = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        EXEC  = 2'd2,
        WRITE = 2'd3
    } state_t;

endpackage

// File: rtl/regfile_op_sequencer_alu.sv
// -----------------------------------------------------------------------------
// regfile_op_alu
// Combinational execute unit for the register-file operation sequencer.
// Produces a (DATA_W+1)-bit result: bits [DATA_W-1:0] are the value to write
// back, bit DATA_W is the carry (ADD) / borrow (SUB) flag, 0 for MOV and LDI.
//
// Optional build macro: SAT_ARITH_EN
//   defined   -> ADD clamps to all-ones on carry, SUB clamps to 0 on borrow
//   undefined -> ADD and SUB wrap modulo 2^DATA_W
//   The flag always reports the raw carry/borrow.
//
// Ports:
//   op_code  in   2         operation (OP_MOV/OP_ADD/OP_SUB/OP_LDI)
//   opa      in   DATA_W    first operand (register read 1)
//   opb      in   DATA_W    second operand (register read 2)
//   imm      in   DATA_W    immediate for LDI
//   result   out  DATA_W+1  {flag, value}
// -----------------------------------------------------------------------------
module regfile_op_alu
    import regfile_op_sequencer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [1:0]        op_code,
    input  logic [DATA_W-1:0] opa,
    input  logic [DATA_W-1:0] opb,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W:0]   result
);

`ifdef SAT_ARITH_EN
    // Replace the value with clamp_val when the extension bit (carry for
    // ADD, borrow for SUB) is set; the flag bit itself is kept.
    function automatic logic [DATA_W:0] saturate(input logic [DATA_W:0]   ext,
                                                 input logic [DATA_W-1:0] clamp_val);
        return ext[DATA_W] ? {1'b1, clamp_val} : ext;
    endfunction
`endif

    logic [DATA_W:0] sum_ext;
    logic [DATA_W:0] diff_ext;

    // Zero-extended subtraction: bit DATA_W is set exactly when opa < opb.
    assign sum_ext  = {1'b0, opa} + {1'b0, opb};
    assign diff_ext = {1'b0, opa} - {1'b0, opb};

    always_comb begin
        result = '0;
        case (op_code)
            OP_MOV: result = {1'b0, opa};
`ifdef SAT_ARITH_EN
            OP_ADD: result = saturate(sum_ext, {DATA_W{1'b1}});
            OP_SUB: result = saturate(diff_ext, {DATA_W{1'b0}});
`else
            OP_ADD: result = sum_ext;
            OP_SUB: result = diff_ext;
`endif
            default: result = {1'b0, imm};
        endcase
    end

endmodule

// File: rtl/regfile_op_sequencer.sv
// -----------------------------------------------------------------------------
// regfile_op_sequencer
// Multi-cycle controller that accepts register-to-register operations over a
// valid/ready handshake and sequences them onto a 2-entry register file:
// accept (IDLE) -> READ -> EXEC -> WRITE. One op per 4 cycles; the write
// strobe and the done pulse occur 3 cycles after the accept cycle.
// This block is the sole master of the register file and drives its reset.
//
// Optional build macro: SAT_ARITH_EN (saturating ADD/SUB, see regfile_op_alu).
//
// Ports:
//   clock, reset              system clock, synchronous active-high reset
//   op_valid / op_ready       request handshake
//   op_code/src1/src2/dst/imm operation fields, sampled on the accept cycle
//   rf_read_register1/2       register-file read addresses
//   rf_read_data1/2           register-file read data (combinational)
//   rf_write_enable/register/data  register-file write port
//   rf_reset                  register-file reset (reloads 2 / 4)
//   done_valid/data/flag      one-cycle completion pulse with written value
//   op_count                  saturating completed-operation counter
// -----------------------------------------------------------------------------
module regfile_op_sequencer
    import regfile_op_sequencer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [1:0]        op_code,
    input  logic              op_src1,
    input  logic              op_src2,
    input  logic              op_dst,
    input  logic [DATA_W-1:0] op_imm,
    output logic              rf_read_register1,
    output logic              rf_read_register2,
    input  logic [DATA_W-1:0] rf_read_data1,
    input  logic [DATA_W-1:0] rf_read_data2,
    output logic              rf_write_enable,
    output logic              rf_write_register,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              rf_reset,
    output logic              done_valid,
    output logic [DATA_W-1:0] done_data,
    output logic              done_flag,
    output logic [CNT_W-1:0]  op_count
);

    state_t            state;
    logic              vld_p2;

    logic [1:0]        op_code_p0;
    logic              src1_p0;
    logic              src2_p0;
    logic              dst_p0;
    logic [DATA_W-1:0] imm_p0;

    logic [DATA_W-1:0] opa_p1;
    logic [DATA_W-1:0] opb_p1;

    logic [DATA_W:0]   alu_result;
    logic [DATA_W:0]   result_p2;

    // The register file gives write priority over its reset, so the write
    // strobe must be suppressed while reset is high or an in-flight op
    // would survive the reset.
    assign rf_reset          = reset;
    assign op_ready          = (state == IDLE) && !reset;
    assign rf_read_register1 = (state == READ) && !reset ? src1_p0 : 1'b0;
    assign rf_read_register2 = (state == READ) && !reset ? src2_p0 : 1'b0;
    assign rf_write_enable   = (state == WRITE) && !reset;
    assign rf_write_register = rf_write_enable ? dst_p0 : 1'b0;
    assign rf_write_data     = result_p2[DATA_W-1:0];

    assign done_valid = vld_p2 && !reset;
    assign done_data  = result_p2[DATA_W-1:0];
    assign done_flag  = result_p2[DATA_W];

    regfile_op_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op_code (op_code_p0),
        .opa     (opa_p1),
        .opb     (opb_p1),
        .imm     (imm_p0),
        .result  (alu_result)
    );

    // FSM, done pulse, result register and counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            vld_p2    <= 1'b0;
            result_p2 <= '0;
            op_count  <= '0;
        end else begin
            vld_p2 <= 1'b0;
            case (state)
                IDLE: begin
                    if (op_valid) state <= READ;
                end
                READ: begin
                    state <= EXEC;
                end
                EXEC: begin
                    state     <= WRITE;
                    vld_p2    <= 1'b1;
                    result_p2 <= alu_result;
                    if (op_count != {CNT_W{1'b1}}) op_count <= op_count + CNT_W'(1);
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // ---- accept stage (p0): latch the request fields ----
    always_ff @(posedge clock) begin
        if (state == IDLE && op_valid) begin
            op_code_p0 <= op_code;
            src1_p0    <= op_src1;
            src2_p0    <= op_src2;
            dst_p0     <= op_dst;
            imm_p0     <= op_imm;
        end
    end

    // ---- read stage (p1): capture register-file operands ----
    always_ff @(posedge clock) begin
        if (state == READ) begin
            opa_p1 <= rf_read_data1;
            opb_p1 <= rf_read_data2;
        end
    end

endmodule

// File: tb/tb_regfile_op_sequencer.sv
`timescale 1ns/1ps
module tb_regfile_op_sequencer;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = 15;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              op_valid = 1'b0;
    logic              op_ready;
    logic [1:0]        op_code = 2'd0;
    logic              op_src1 = 1'b0;
    logic              op_src2 = 1'b0;
    logic              op_dst = 1'b0;
    logic [DATA_W-1:0] op_imm = '0;
    logic              rf_read_register1, rf_read_register2;
    logic [DATA_W-1:0] rf_read_data1, rf_read_data2;
    logic              rf_write_enable, rf_write_register;
    logic [DATA_W-1:0] rf_write_data;
    logic              rf_reset;
    logic              done_valid;
    logic [DATA_W-1:0] done_data;
    logic              done_flag;
    logic [CNT_W-1:0]  op_count;

    logic [DATA_W-1:0] rf_regs [2];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit run_chk = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    regfile_op_sequencer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clock             (clock),
        .reset             (reset),
        .op_valid          (op_valid),
        .op_ready          (op_ready),
        .op_code           (op_code),
        .op_src1           (op_src1),
        .op_src2           (op_src2),
        .op_dst            (op_dst),
        .op_imm            (op_imm),
        .rf_read_register1 (rf_read_register1),
        .rf_read_register2 (rf_read_register2),
        .rf_read_data1     (rf_read_data1),
        .rf_read_data2     (rf_read_data2),
        .rf_write_enable   (rf_write_enable),
        .rf_write_register (rf_write_register),
        .rf_write_data     (rf_write_data),
        .rf_reset          (rf_reset),
        .done_valid        (done_valid),
        .done_data         (done_data),
        .done_flag         (done_flag),
        .op_count          (op_count)
    );

    // Register file the sequencer drives: write has priority over reset.
    always @(posedge clock) begin
        if (rf_write_enable) rf_regs[rf_write_register] <= rf_write_data;
        else if (rf_reset) begin
            rf_regs[0] <= 8'd2;
            rf_regs[1] <= 8'd4;
        end
    end
    assign rf_read_data1 = rf_regs[rf_read_register1];
    assign rf_read_data2 = rf_regs[rf_read_register2];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference semantics of one operation on plain integers.
    function automatic void model_op(input int code, input int a, input int b, input int imm,
                                     output int d, output int f);
        int raw;
        d = 0;
        f = 0;
        case (code)
            0: d = a;
            1: begin
                raw = a + b;
                f = (raw > 255) ? 1 : 0;
`ifdef SAT_ARITH_EN
                d = (f != 0) ? 255 : raw;
`else
                d = raw % 256;
`endif
            end
            2: begin
                f = (a < b) ? 1 : 0;
`ifdef SAT_ARITH_EN
                d = (f != 0) ? 0 : a - b;
`else
                d = (a - b + 256) % 256;
`endif
            end
            default: d = imm;
        endcase
    endfunction

    // Reference model state: one op in flight at most, tracked by age.
    int m_regs [2] = '{2, 4};
    int m_age = 0;
    int m_cnt = 0;
    int p_code = 0, p_s1 = 0, p_s2 = 0, p_dst = 0, p_imm = 0, p_data = 0, p_flag = 0;

    always @(negedge clock) begin
        if (run_chk) begin
            check("reg0", rf_regs[0], m_regs[0]);
            check("reg1", rf_regs[1], m_regs[1]);
            check("rf_reset", rf_reset, reset);
            if (reset) begin
                check("ready_in_reset", op_ready, 0);
                check("we_in_reset", rf_write_enable, 0);
                check("done_in_reset", done_valid, 0);
                m_age = 0;
                m_cnt = 0;
                m_regs[0] = 2;
                m_regs[1] = 4;
            end else begin
                check("op_ready", op_ready, (m_age == 0) ? 1 : 0);
                check("done_valid", done_valid, (m_age == 3) ? 1 : 0);
                check("write_enable", rf_write_enable, (m_age == 3) ? 1 : 0);
                if (m_age == 1) begin
                    check("rd_addr1", rf_read_register1, p_s1);
                    check("rd_addr2", rf_read_register2, p_s2);
                    model_op(p_code, m_regs[p_s1], m_regs[p_s2], p_imm, p_data, p_flag);
                end
                if (m_age == 3) begin
                    check("done_data", done_data, p_data);
                    check("done_flag", done_flag, p_flag);
                    check("wr_addr", rf_write_register, p_dst);
                    check("wr_data", rf_write_data, p_data);
                    if (m_cnt < CNT_MAX) m_cnt++;
                    m_regs[p_dst] = p_data;
                end
                check("op_count", op_count, m_cnt);
                if (m_age == 0) begin
                    if (op_valid) begin
                        p_code = op_code; p_s1 = op_src1; p_s2 = op_src2;
                        p_dst = op_dst; p_imm = op_imm;
                        m_age = 1;
                    end
                end else begin
                    m_age = (m_age + 1) % 4;
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset(input int n);
        reset = 1'b1;
        op_valid = 1'b0;
        repeat (n) step();
        reset = 1'b0;
        #1;
    endtask

    // Issue one op from an idle cycle, wait (bounded) for its done pulse,
    // check latency and literal result, then advance to the next idle cycle.
    task automatic run_op(input string name, input logic [1:0] code, input logic s1,
                          input logic s2, input logic d, input logic [7:0] imm,
                          input bit hold, input int exp_data, input int exp_flag,
                          output int done_cyc);
        bit seen;
        seen = 0;
        done_cyc = -1;
        check({name, "_ready"}, op_ready, 1);
        op_valid = 1'b1; op_code = code; op_src1 = s1; op_src2 = s2; op_dst = d; op_imm = imm;
        for (int i = 1; i <= 8 && !seen; i++) begin
            step();
            if (!hold || i >= 3) op_valid = 1'b0;
            if (done_valid) begin
                seen = 1;
                done_cyc = cyc;
                check({name, "_latency"}, i, 3);
                check({name, "_data"}, done_data, exp_data);
                check({name, "_flag"}, done_flag, exp_flag);
            end
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: no done_valid within 8 cycles, required one at cycle 3", name);
        end
        op_valid = 1'b0;
        step();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int c1, c2, dummy;

        // Reset and reset-state values.
        reset = 1'b1;
        step();
        run_chk = 1;
        check("rst_ready", op_ready, 0);
        check("rst_rf_reset", rf_reset, 1);
        step();
        reset = 1'b0;
        #1;
        check("post_rst_ready", op_ready, 1);
        check("post_rst_count", op_count, 0);
        check("post_rst_done", done_valid, 0);
        check("post_rst_done_data", done_data, 0);
        check("post_rst_done_flag", done_flag, 0);
        check("post_rst_we", rf_write_enable, 0);
        check("post_rst_wa", rf_write_register, 0);
        check("post_rst_ra1", rf_read_register1, 0);
        check("post_rst_ra2", rf_read_register2, 0);

        // MOV r0 <- r1.
        run_op("mov", 2'd0, 1'b1, 1'b0, 1'b0, 8'h00, 0, 4, 0, dummy);
        check("mov_reg0", rf_regs[0], 4);
        check("mov_count", op_count, 1);

        // ADD r1 <- r0 + r1 with op_valid held through the busy cycles.
        apply_reset(1);
        run_op("add", 2'd1, 1'b0, 1'b1, 1'b1, 8'h00, 1, 6, 0, dummy);
        check("add_reg1", rf_regs[1], 6);
        check("add_count", op_count, 1);

        // Carry case.
        run_op("ldi_f0", 2'd3, 1'b0, 1'b0, 1'b0, 8'hF0, 0, 8'hF0, 0, dummy);
        run_op("ldi_20", 2'd3, 1'b1, 1'b1, 1'b1, 8'h20, 0, 8'h20, 0, dummy);
`ifdef SAT_ARITH_EN
        run_op("add_carry", 2'd1, 1'b0, 1'b1, 1'b0, 8'h00, 0, 8'hFF, 1, dummy);
`else
        run_op("add_carry", 2'd1, 1'b0, 1'b1, 1'b0, 8'h00, 0, 8'h10, 1, dummy);
`endif

        // Borrow case: 2 - 4.
        apply_reset(1);
`ifdef SAT_ARITH_EN
        run_op("sub_borrow", 2'd2, 1'b0, 1'b1, 1'b0, 8'h00, 0, 8'h00, 1, dummy);
`else
        run_op("sub_borrow", 2'd2, 1'b0, 1'b1, 1'b0, 8'h00, 0, 8'hFE, 1, dummy);
`endif

        // Dependent back-to-back ops.
        run_op("ldi_7", 2'd3, 1'b0, 1'b0, 1'b1, 8'h07, 0, 7, 0, c1);
        run_op("mov_dep", 2'd0, 1'b1, 1'b0, 1'b0, 8'h00, 0, 7, 0, c2);
        check("done_spacing", c2 - c1, 4);

        // Reset during the EXEC cycle of an ADD drops the op.
        op_valid = 1'b1; op_code = 2'd1; op_src1 = 1'b0; op_src2 = 1'b1; op_dst = 1'b0;
        step();
        op_valid = 1'b0;
        step();
        reset = 1'b1;
        #1;
        check("midrst_we", rf_write_enable, 0);
        check("midrst_done", done_valid, 0);
        step();
        reset = 1'b0;
        #1;
        check("midrst_ready_after", op_ready, 1);
        check("midrst_done_after", done_valid, 0);
        check("midrst_reg0", rf_regs[0], 2);
        check("midrst_reg1", rf_regs[1], 4);
        repeat (4) begin
            step();
            check("midrst_no_late_done", done_valid, 0);
        end

        // Randomized traffic, including occasional resets at any point.
        for (int i = 0; i < 600; i++) begin
            reset    = ($urandom_range(0, 79) == 0);
            op_valid = ($urandom_range(0, 2) != 0);
            op_code  = 2'($urandom_range(0, 3));
            op_src1  = 1'($urandom_range(0, 1));
            op_src2  = 1'($urandom_range(0, 1));
            op_dst   = 1'($urandom_range(0, 1));
            op_imm   = 8'($urandom_range(0, 255));
            step();
        end
        reset = 1'b0;
        op_valid = 1'b0;

        // Counter saturation.
        apply_reset(1);
        for (int i = 0; i < CNT_MAX + 2; i++) begin
            run_op("ldi_sat", 2'd3, 1'b0, 1'b0, 1'($unsigned(i) & 1), 8'(i), 0, i, 0, dummy);
        end
        check("count_saturated", op_count, CNT_MAX);

        step();
        run_chk = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
